// File: rtl/uart_pkg.sv
// Shared constants, register map, FSM encoding and helpers for the MMIO UART transmitter.
package uart_pkg;

  // Register offsets, selected by address[3:2]
  localparam logic [1:0] TXDATA_OFS  = 2'd0;
  localparam logic [1:0] STATUS_OFS  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFS = 2'd2;
  localparam logic [1:0] RSVD_OFS    = 2'd3;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 4;

  // Frame constants
  localparam int         DATA_BITS    = 8;
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

  // Transmit FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A programmed divider of 0 behaves as 1 so a bit never lasts zero cycles
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

  // Assemble the STATUS read word
  function automatic logic [31:0] status_word(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [3:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[STATUS_BUSY_BIT]           = busy;
    w[STATUS_FULL_BIT]           = full;
    w[STATUS_EMPTY_BIT]          = empty;
    w[STATUS_OVF_BIT]            = ovf;
    w[STATUS_COUNT_LSB +: 4]     = count;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with combinational head output; push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointers wrap naturally; occupancy tracks accepted pushes and pops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so no stale data is ever observable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file, TX FIFO,
// bit timer and shift FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        dram_read,
  input  logic        dram_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           ofs_s;
  logic                 wr_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [CW-1:0]        count_s;
  logic [3:0]           count4_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 unused_s;

  logic [15:0]          bauddiv_r;
  logic                 ovf_r;

  tx_state_t            state_r, state_n;
  logic [15:0]          timer_r, timer_n;
  logic [15:0]          lat_r, lat_n;
  logic [2:0]           idx_r, idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 txd_r, txd_n;
  logic                 bit_end_s;

  assign hit       = (address[31:4] == BASE_ADDR[31:4]);
  assign ofs_s     = address[3:2];
  assign wr_s      = dram_write && hit;
  assign push_s    = wr_s && (ofs_s == TXDATA_OFS);
  assign count4_s  = 4'(count_s);
  assign bit_end_s = (timer_r == lat_r - 16'd1);
  assign txd       = txd_r;
  assign unused_s  = ^{address[1:0], write_data[31:16]};

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (write_data[DATA_BITS-1:0]),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Register file: BAUDDIV storage and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bauddiv_r <= CLKS_PER_BIT;
      ovf_r     <= 1'b0;
    end else begin
      if (wr_s && (ofs_s == BAUDDIV_OFS)) bauddiv_r <= write_data[15:0];
      if (push_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && (ofs_s == STATUS_OFS) && write_data[STATUS_OVF_BIT]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Combinational read mux; zero unless a read hits this window
  always_comb begin
    read_data = 32'd0;
    if (dram_read && hit) begin
      case (ofs_s)
        STATUS_OFS:  read_data = status_word(state_r != ST_IDLE, full_s, empty_s, ovf_r, count4_s);
        BAUDDIV_OFS: read_data = {16'd0, bauddiv_r};
        default:     read_data = 32'd0;
      endcase
    end else begin
      read_data = 32'd0;
    end
  end

  // Transmit state, bit timer and serial output register; reset forces txd high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      timer_r <= 16'd0;
      lat_r   <= eff_div(CLKS_PER_BIT);
      idx_r   <= 3'd0;
      shift_r <= '0;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      lat_r   <= lat_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      txd_r   <= txd_n;
    end
  end

  // Next-state logic: a frame starts by popping the head and latching the divider
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    lat_n   = lat_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    txd_n   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = head_s;
          lat_n   = eff_div(bauddiv_r);
          timer_n = 16'd0;
          state_n = ST_START;
          txd_n   = 1'b0;
        end else begin
          timer_n = 16'd0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          timer_n = 16'd0;
          idx_n   = 3'd0;
          txd_n   = shift_r[0];
          shift_n = {1'b0, shift_r[DATA_BITS-1:1]};
          state_n = ST_DATA;
        end else begin
          timer_n = timer_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          timer_n = 16'd0;
          if (idx_r == LAST_BIT_IDX) begin
            txd_n   = 1'b1;
            state_n = ST_STOP;
          end else begin
            idx_n   = idx_r + 3'd1;
            txd_n   = shift_r[0];
            shift_n = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          timer_n = timer_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          timer_n = 16'd0;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_n = head_s;
            lat_n   = eff_div(bauddiv_r);
            state_n = ST_START;
            txd_n   = 1'b0;
          end else begin
            state_n = ST_IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          timer_n = timer_r + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized self-checking bench for mmio_uart_tx against a frame-level serial model.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX = 32'h0000_1000;
  localparam logic [31:0] A_ST = 32'h0000_1004;
  localparam logic [31:0] A_BD = 32'h0000_1008;
  localparam logic [31:0] A_RS = 32'h0000_100C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        dram_read;
  logic        dram_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        txd;

  int vectors     = 0;
  int miscompares = 0;

  // Expected txd per clock from the first start-bit clock, and frame start indices
  bit exp_txd[$];
  int frame_start[$];

  logic [7:0] bytes_a [4];
  int         div;
  int         nbytes;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .dram_read  (dram_read),
    .dram_write (dram_write),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .txd        (txd)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // 8N1 frame: start 0, eight data bits LSB first, stop 1, each held eff(d) clocks
  function automatic void add_frame(input logic [7:0] b, input int d);
    frame_start.push_back(exp_txd.size());
    for (int i = 0; i < 10; i++) begin
      bit v;
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = 1'b1;
      else             v = b[i-1];
      for (int c = 0; c < eff(d); c++) exp_txd.push_back(v);
    end
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    address    = addr;
    write_data = data;
    dram_read  = 1'b0;
    dram_write = 1'b1;
    @(negedge clk);
    dram_write = 1'b0;
  endtask

  task automatic bus_read_check(input string tag, input logic [31:0] addr,
                                input logic [31:0] exp_data, input logic exp_hit);
    address   = addr;
    dram_read = 1'b1;
    #1;
    check_val(tag, read_data, exp_data);
    check_val({tag, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
    dram_read = 1'b0;
  endtask

  // Compare txd clock by clock with the model; called at the negedge after the first push
  task automatic run_stream(input string tag);
    int n;
    int nf;
    n  = exp_txd.size();
    nf = frame_start.size();
    #1;
    check_val({tag, " pre"}, {31'd0, txd}, 32'd1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("%s txd[%0d]", tag, k), {31'd0, txd}, {31'd0, exp_txd[k]});
      if (dram_read && !dram_write && address == A_ST) begin
        int popped;
        popped = 0;
        foreach (frame_start[j]) if (frame_start[j] <= k) popped++;
        check_val($sformatf("%s busy[%0d]", tag, k), {31'd0, read_data[0]}, 32'd1);
        check_val($sformatf("%s count[%0d]", tag, k), {28'd0, read_data[7:4]}, 32'(nf - popped));
      end
    end
    @(negedge clk);
    #1;
    check_val({tag, " idle_txd"}, {31'd0, txd}, 32'd1);
    address   = A_ST;
    dram_read = 1'b1;
    #1;
    check_val({tag, " end_status"}, read_data, 32'h4);
    dram_read = 1'b0;
    exp_txd.delete();
    frame_start.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    address    = 32'd0;
    write_data = 32'd0;
    dram_read  = 1'b0;
    dram_write = 1'b0;
    do_reset();

    // Reset state and decode
    check_val("rst_txd", {31'd0, txd}, 32'd1);
    bus_read_check("rst_status", A_ST, 32'h4, 1'b1);
    bus_read_check("rst_bauddiv", A_BD, 32'd16, 1'b1);
    bus_read_check("miss_read", 32'h0000_2000, 32'd0, 1'b0);
    bus_read_check("txdata_read", A_TX, 32'd0, 1'b1);

    // Reserved and non-hit writes have no effect
    @(negedge clk);
    bus_write(A_RS, 32'hFFFF_FFFF);
    bus_write(32'h0000_2000, 32'h0000_0077);
    repeat (4) @(negedge clk);
    check_val("miss_write_txd", {31'd0, txd}, 32'd1);
    bus_read_check("rsvd_read", A_RS, 32'd0, 1'b1);
    bus_read_check("miss_write_status", A_ST, 32'h4, 1'b1);

    // Single frame 0xA5 at 4 clocks per bit
    @(negedge clk);
    bus_write(A_BD, 32'd4);
    add_frame(8'hA5, 4);
    bus_write(A_TX, 32'h0000_00A5);
    address   = A_ST;
    dram_read = 1'b1;
    run_stream("a5");

    // Three back-to-back frames, no gap between stop and next start
    @(negedge clk);
    add_frame(8'h55, 4);
    add_frame(8'h0F, 4);
    add_frame(8'hF0, 4);
    fork
      begin
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h0F);
        bus_write(A_TX, 32'hF0);
        address   = A_ST;
        dram_read = 1'b1;
      end
      begin
        @(negedge clk);
        run_stream("b2b");
      end
    join

    // Stalled transmitter: fill FIFO, overflow, clear overflow
    @(negedge clk);
    bus_write(A_BD, 32'd1000);
    for (int i = 0; i < 10; i++) bus_write(A_TX, $urandom_range(0, 255));
    check_val("stall_txd", {31'd0, txd}, 32'd0);
    bus_read_check("ovf_status", A_ST, 32'h8B, 1'b1);
    bus_write(A_ST, 32'h8);
    bus_read_check("ovf_clear", A_ST, 32'h83, 1'b1);
    bus_read_check("bd_1000", A_BD, 32'd1000, 1'b1);
    do_reset();
    bus_read_check("post_stall_status", A_ST, 32'h4, 1'b1);

    // BAUDDIV change mid-frame applies to the next frame only
    bus_write(A_BD, 32'd4);
    add_frame(8'h3C, 4);
    add_frame(8'hC9, 8);
    fork
      begin
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC9);
        address   = A_ST;
        dram_read = 1'b1;
        repeat (8) @(negedge clk);
        bus_write(A_BD, 32'd8);
        address   = A_ST;
        dram_read = 1'b1;
      end
      begin
        @(negedge clk);
        run_stream("baud_chg");
      end
    join

    // Divider of 0 behaves as 1 clock per bit
    @(negedge clk);
    bus_write(A_BD, 32'd0);
    bus_read_check("bd_zero", A_BD, 32'd0, 1'b1);
    @(negedge clk);
    add_frame(8'h6B, 0);
    bus_write(A_TX, 32'h6B);
    address   = A_ST;
    dram_read = 1'b1;
    run_stream("div0");

    // Randomized bursts with random dividers
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      div    = $urandom_range(0, 5);
      nbytes = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) bytes_a[i] = 8'($urandom_range(0, 255));
      bus_write(A_BD, 32'(div));
      for (int i = 0; i < nbytes; i++) add_frame(bytes_a[i], div);
      fork
        begin
          for (int i = 0; i < nbytes; i++) bus_write(A_TX, {24'd0, bytes_a[i]});
          address   = A_ST;
          dram_read = 1'b1;
        end
        begin
          @(negedge clk);
          run_stream($sformatf("rnd%0d", t));
        end
      join
    end

    // Reset during DATA bit 3 aborts the frame immediately
    @(negedge clk);
    bus_write(A_BD, 32'd4);
    add_frame(8'hF0, 4);
    bus_write(A_TX, 32'hF0);
    address   = A_ST;
    dram_read = 1'b1;
    #1;
    check_val("abort pre", {31'd0, txd}, 32'd1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("abort txd[%0d]", k), {31'd0, txd}, {31'd0, exp_txd[k]});
    end
    reset = 1'b0;
    #1;
    check_val("abort_txd_high", {31'd0, txd}, 32'd1);
    check_val("abort_status_in_reset", read_data, 32'h4);
    exp_txd.delete();
    frame_start.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("post_abort txd[%0d]", k), {31'd0, txd}, 32'd1);
    end
    check_val("post_abort_status", read_data, 32'h4);
    dram_read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
